// File: rtl/gpgpu_simt_pkg.sv
// Shared definitions for the SIMT divergence path: push-packet field offsets,
// the bottom-of-stack RPC sentinel and the divergence FSM encoding.
package gpgpu_simt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } div_state_e;

  // Packets are {RPC, PC, Mask}, with the mask in the LSBs.
  localparam int PKT_MASK_LSB = 0;

  function automatic int pkt_pc_lsb(input int lanes);
    return lanes;
  endfunction

  function automatic int pkt_rpc_lsb(input int lanes, input int pc_w);
    return lanes + pc_w;
  endfunction

  // The bottom stack entry carries an all-ones RPC; slice to the PC width.
  localparam logic [63:0] RPC_SENTINEL = '1;

endpackage

// File: rtl/simt_diverge_ctrl_reconv_slot.sv
// Reconvergence detection plus a one-entry holding slot that defers a reconv
// while it would collide with a branch strobe or with the warp being pushed.
module reconv_slot
  import gpgpu_simt_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int WID_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             iss_valid,
  input  logic [WID_W-1:0] iss_warp,
  input  logic [PC_W-1:0]  iss_next_pc,
  input  logic [PC_W-1:0]  iss_tos_rpc,
  input  logic             branch_now,
  input  logic             push_active,
  input  logic [WID_W-1:0] push_warp,
  output logic             emit,
  output logic [WID_W-1:0] emit_warp
);

  localparam logic [PC_W-1:0] SENTINEL = RPC_SENTINEL[PC_W-1:0];

  logic             slot_valid, slot_valid_d;
  logic [WID_W-1:0] slot_warp, slot_warp_d;
  logic             detect, blk_det, blk_slot, overflow;

  assign detect   = iss_valid && (iss_next_pc == iss_tos_rpc) && (iss_tos_rpc != SENTINEL);
  assign blk_det  = branch_now || (push_active && (iss_warp == push_warp));
  assign blk_slot = branch_now || (push_active && (slot_warp == push_warp));

  // The held entry always goes first; a detection in its drain cycle takes its place.
  always_comb begin
    emit         = 1'b0;
    emit_warp    = '0;
    slot_valid_d = slot_valid;
    slot_warp_d  = slot_warp;
    overflow     = 1'b0;
    if (slot_valid) begin
      if (!blk_slot) begin
        emit         = 1'b1;
        emit_warp    = slot_warp;
        slot_valid_d = detect;
        slot_warp_d  = detect ? iss_warp : slot_warp;
      end else if (detect) begin
        overflow = 1'b1;
      end
    end else if (detect) begin
      if (blk_det) begin
        slot_valid_d = 1'b1;
        slot_warp_d  = iss_warp;
      end else begin
        emit      = 1'b1;
        emit_warp = iss_warp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_warp  <= '0;
    end else if (!stall) begin
      slot_valid <= slot_valid_d;
      slot_warp  <= slot_warp_d;
    end
  end

  slot_overflow_a : assert property (@(posedge clk) disable iff (reset) !(overflow && !stall));

endmodule

// File: rtl/simt_diverge_ctrl.sv
// Branch-divergence controller feeding the per-warp SIMT stacks.
// Optional SIMT_DIVERGE_STATS_EN adds saturating divergent/uniform/reconv event counters.
module simt_diverge_ctrl
  import gpgpu_simt_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int LANES = 8,
  parameter int WID_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_i,
  input  logic                      br_valid_i,
  input  logic [WID_W-1:0]          br_warp_i,
  input  logic [LANES-1:0]          br_taken_i,
  input  logic [PC_W-1:0]           br_target_pc_i,
  input  logic [PC_W-1:0]           br_fall_pc_i,
  input  logic [PC_W-1:0]           br_reconv_pc_i,
  input  logic [PC_W-1:0]           tos_rpc_i,
  input  logic [LANES-1:0]          tos_mask_i,
  input  logic                      iss_valid_i,
  input  logic [WID_W-1:0]          iss_warp_i,
  input  logic [PC_W-1:0]           iss_next_pc_i,
  input  logic [PC_W-1:0]           iss_tos_rpc_i,
  output logic                      busy_o,
  output logic                      branch_o,
  output logic                      pushState_o,
  output logic                      pushTOS_o,
  output logic                      pushTOSsub1_o,
  output logic                      reconv_o,
  output logic                      mask0_all0_o,
  output logic                      mask1_all0_o,
  output logic [WID_W-1:0]          branchWarp_o,
  output logic [WID_W-1:0]          preBranchWarp_o,
  output logic [WID_W-1:0]          issuedWarp_o,
  output logic [2*PC_W+LANES-1:0]   pushPacket_TOS_o,
  output logic [2*PC_W+LANES-1:0]   pushPacket_TOSsub1_o
`ifdef SIMT_DIVERGE_STATS_EN
  ,
  output logic [31:0]               stat_div_o,
  output logic [31:0]               stat_uni_o,
  output logic [31:0]               stat_reconv_o
`endif
);

  localparam int PKT_W    = 2*PC_W + LANES;
  localparam int MASK_LSB = PKT_MASK_LSB;
  localparam int PC_LSB   = pkt_pc_lsb(LANES);
  localparam int RPC_LSB  = pkt_rpc_lsb(LANES, PC_W);

  div_state_e state_q, state_d;

  logic [LANES-1:0] m0, m1;
  logic             divergent, push_active;

  logic [WID_W-1:0] lat_warp;
  logic [PC_W-1:0]  lat_target, lat_fall, lat_reconv;
  logic [LANES-1:0] lat_m0, lat_m1;

  logic             busy_d, branch_d, push_state_d, push_tos_d, push_sub1_d, reconv_d;
  logic             m0z_d, m1z_d;
  logic [WID_W-1:0] bw_d, pbw_d, iw_d;
  logic [PKT_W-1:0] pkt_tos_d, pkt_sub1_d;

  assign m1          = br_taken_i;
  assign m0          = tos_mask_i & ~br_taken_i;
  assign divergent   = (m0 != '0) && (m1 != '0);
  assign push_active = (state_q == ST_PUSH);

  reconv_slot #(
    .PC_W  (PC_W),
    .WID_W (WID_W)
  ) u_slot (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall_i),
    .iss_valid   (iss_valid_i),
    .iss_warp    (iss_warp_i),
    .iss_next_pc (iss_next_pc_i),
    .iss_tos_rpc (iss_tos_rpc_i),
    .branch_now  (branch_d),
    .push_active (push_active),
    .push_warp   (lat_warp),
    .emit        (reconv_d),
    .emit_warp   (iw_d)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = 1'b0;
    branch_d     = 1'b0;
    push_state_d = 1'b0;
    push_tos_d   = 1'b0;
    push_sub1_d  = 1'b0;
    m0z_d        = 1'b0;
    m1z_d        = 1'b0;
    bw_d         = '0;
    pbw_d        = '0;
    pkt_tos_d    = '0;
    pkt_sub1_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid_i) begin
          push_tos_d                        = 1'b1;
          bw_d                              = br_warp_i;
          m0z_d                             = (m0 == '0);
          m1z_d                             = (m1 == '0);
          pkt_tos_d[RPC_LSB +: PC_W]        = tos_rpc_i;
          pkt_tos_d[MASK_LSB +: LANES]      = tos_mask_i;
          if (divergent) begin
            // Current TOS becomes the reconvergence entry; the split paths follow.
            branch_d                        = 1'b1;
            pkt_tos_d[PC_LSB +: PC_W]       = br_reconv_pc_i;
            state_d                         = ST_PUSH;
          end else begin
            pkt_tos_d[PC_LSB +: PC_W]       = (m1 != '0) ? br_target_pc_i : br_fall_pc_i;
          end
        end
      end
      ST_PUSH: begin
        state_d                             = ST_IDLE;
        busy_d                              = 1'b1;
        push_state_d                        = 1'b1;
        push_tos_d                          = 1'b1;
        push_sub1_d                         = 1'b1;
        pbw_d                               = lat_warp;
        // Taken path lands on top so it executes first.
        pkt_tos_d[RPC_LSB +: PC_W]          = lat_reconv;
        pkt_tos_d[PC_LSB +: PC_W]           = lat_target;
        pkt_tos_d[MASK_LSB +: LANES]        = lat_m1;
        pkt_sub1_d[RPC_LSB +: PC_W]         = lat_reconv;
        pkt_sub1_d[PC_LSB +: PC_W]          = lat_fall;
        pkt_sub1_d[MASK_LSB +: LANES]       = lat_m0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      lat_warp             <= '0;
      lat_target           <= '0;
      lat_fall             <= '0;
      lat_reconv           <= '0;
      lat_m0               <= '0;
      lat_m1               <= '0;
      busy_o               <= 1'b0;
      branch_o             <= 1'b0;
      pushState_o          <= 1'b0;
      pushTOS_o            <= 1'b0;
      pushTOSsub1_o        <= 1'b0;
      reconv_o             <= 1'b0;
      mask0_all0_o         <= 1'b0;
      mask1_all0_o         <= 1'b0;
      branchWarp_o         <= '0;
      preBranchWarp_o      <= '0;
      issuedWarp_o         <= '0;
      pushPacket_TOS_o     <= '0;
      pushPacket_TOSsub1_o <= '0;
    end else if (!stall_i) begin
      state_q              <= state_d;
      if (branch_d) begin
        lat_warp           <= br_warp_i;
        lat_target         <= br_target_pc_i;
        lat_fall           <= br_fall_pc_i;
        lat_reconv         <= br_reconv_pc_i;
        lat_m0             <= m0;
        lat_m1             <= m1;
      end
      busy_o               <= busy_d;
      branch_o             <= branch_d;
      pushState_o          <= push_state_d;
      pushTOS_o            <= push_tos_d;
      pushTOSsub1_o        <= push_sub1_d;
      reconv_o             <= reconv_d;
      mask0_all0_o         <= m0z_d;
      mask1_all0_o         <= m1z_d;
      branchWarp_o         <= bw_d;
      preBranchWarp_o      <= pbw_d;
      issuedWarp_o         <= iw_d;
      pushPacket_TOS_o     <= pkt_tos_d;
      pushPacket_TOSsub1_o <= pkt_sub1_d;
    end
  end

`ifdef SIMT_DIVERGE_STATS_EN
  logic uni_evt;
  assign uni_evt = (state_q == ST_IDLE) && br_valid_i && !divergent;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_div_o    <= '0;
      stat_uni_o    <= '0;
      stat_reconv_o <= '0;
    end else if (!stall_i) begin
      if (branch_d && (stat_div_o != '1))    stat_div_o    <= stat_div_o + 32'd1;
      if (uni_evt && (stat_uni_o != '1))     stat_uni_o    <= stat_uni_o + 32'd1;
      if (reconv_d && (stat_reconv_o != '1)) stat_reconv_o <= stat_reconv_o + 32'd1;
    end
  end
`endif

  br_in_push_a : assert property (@(posedge clk) disable iff (reset)
    !(!stall_i && (state_q == ST_PUSH) && br_valid_i));
  strobe_excl_a : assert property (@(posedge clk) disable iff (reset)
    !(branch_o && reconv_o) && !(branch_o && pushState_o));

endmodule

// File: tb/tb_simt_diverge_ctrl.sv
// Bench for simt_diverge_ctrl: fixed vectors, hand sequences for the multi-cycle
// cases, then random traffic against a queue-based behavioural model.
module tb_simt_diverge_ctrl;

  localparam int PC_W  = 12;
  localparam int LANES = 8;
  localparam int WID_W = 3;

  typedef struct packed {
    logic        busy, branch, push_state, push_tos, push_sub1, reconv, m0z, m1z;
    logic [2:0]  bw, pbw, iw;
    logic [31:0] tos, sub1;
  } out_t;

  typedef struct {
    logic        br_valid;
    logic [2:0]  br_warp;
    logic [7:0]  taken, mask;
    logic [11:0] target, fall, rc, rpc;
    logic        iss_valid;
    logic [2:0]  iss_warp;
    logic [11:0] iss_next, iss_rpc;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_warp = '0;
  logic [7:0]  br_taken = '0, tos_mask = '0;
  logic [11:0] br_target = '0, br_fall = '0, br_reconv = '0, tos_rpc = '0;
  logic        iss_valid = 1'b0;
  logic [2:0]  iss_warp = '0;
  logic [11:0] iss_next = '0, iss_rpc = '0;

  logic        busy, branch, push_state, push_tos, push_sub1, reconv, m0z, m1z;
  logic [2:0]  bw, pbw, iw;
  logic [31:0] pkt_tos, pkt_sub1;
  out_t        dut_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  simt_diverge_ctrl #(.PC_W(PC_W), .LANES(LANES), .WID_W(WID_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .stall_i              (stall),
    .br_valid_i           (br_valid),
    .br_warp_i            (br_warp),
    .br_taken_i           (br_taken),
    .br_target_pc_i       (br_target),
    .br_fall_pc_i         (br_fall),
    .br_reconv_pc_i       (br_reconv),
    .tos_rpc_i            (tos_rpc),
    .tos_mask_i           (tos_mask),
    .iss_valid_i          (iss_valid),
    .iss_warp_i           (iss_warp),
    .iss_next_pc_i        (iss_next),
    .iss_tos_rpc_i        (iss_rpc),
    .busy_o               (busy),
    .branch_o             (branch),
    .pushState_o          (push_state),
    .pushTOS_o            (push_tos),
    .pushTOSsub1_o        (push_sub1),
    .reconv_o             (reconv),
    .mask0_all0_o         (m0z),
    .mask1_all0_o         (m1z),
    .branchWarp_o         (bw),
    .preBranchWarp_o      (pbw),
    .issuedWarp_o         (iw),
    .pushPacket_TOS_o     (pkt_tos),
    .pushPacket_TOSsub1_o (pkt_sub1)
  );

  assign dut_out = {busy, branch, push_state, push_tos, push_sub1, reconv, m0z, m1z,
                    bw, pbw, iw, pkt_tos, pkt_sub1};

  // strobes: {busy, branch, pushState, pushTOS, pushTOSsub1, reconv, mask0_all0, mask1_all0}
  function automatic out_t mk(input logic [7:0] s, input logic [2:0] b, input logic [2:0] p,
                              input logic [2:0] i, input logic [31:0] t, input logic [31:0] s1);
    out_t o;
    o = {s, b, p, i, t, s1};
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_pend = 1'b0;
  logic [2:0]  m_pw = '0;
  logic [11:0] m_tg = '0, m_fl = '0, m_rc = '0;
  logic [7:0]  m_m0 = '0, m_m1 = '0;
  logic [2:0]  m_q[$];
  out_t        m_exp = '0;

  function automatic bit m_detect();
    return iss_valid && (iss_next == iss_rpc) && (iss_rpc != 12'hFFF);
  endfunction

  function automatic bit m_div_now();
    logic [7:0] a0, a1;
    a1 = br_taken;
    a0 = tos_mask & ~br_taken;
    return !m_pend && br_valid && (a0 != 0) && (a1 != 0);
  endfunction

  function automatic bit m_blocked(input logic [2:0] w, input bit dv);
    return dv || (m_pend && (w == m_pw));
  endfunction

  function automatic bit would_overflow();
    return (m_q.size() != 0) && m_detect() && m_blocked(m_q[0], m_div_now());
  endfunction

  task automatic model_step();
    out_t e;
    bit dv, det;
    logic [7:0] a0, a1;
    if (reset) begin
      m_exp  = '0;
      m_pend = 1'b0;
      m_q.delete();
    end else if (!stall) begin
      e   = '0;
      dv  = m_div_now();
      det = m_detect();
      if (m_q.size() != 0) begin
        if (!m_blocked(m_q[0], dv)) begin
          e.reconv = 1'b1;
          e.iw     = m_q.pop_front();
          if (det) m_q.push_back(iss_warp);
        end
      end else if (det) begin
        if (m_blocked(iss_warp, dv)) m_q.push_back(iss_warp);
        else begin
          e.reconv = 1'b1;
          e.iw     = iss_warp;
        end
      end
      if (m_pend) begin
        e.busy = 1'b1; e.push_state = 1'b1; e.push_tos = 1'b1; e.push_sub1 = 1'b1;
        e.pbw  = m_pw;
        e.tos  = {m_rc, m_tg, m_m1};
        e.sub1 = {m_rc, m_fl, m_m0};
        m_pend = 1'b0;
      end else if (br_valid) begin
        a1 = br_taken;
        a0 = tos_mask & ~br_taken;
        e.push_tos = 1'b1;
        e.bw  = br_warp;
        e.m0z = (a0 == 0);
        e.m1z = (a1 == 0);
        if (dv) begin
          e.branch = 1'b1;
          e.tos  = {tos_rpc, br_reconv, tos_mask};
          m_pend = 1'b1;
          m_pw = br_warp; m_tg = br_target; m_fl = br_fall; m_rc = br_reconv;
          m_m0 = a0; m_m1 = a1;
        end else begin
          e.tos = {tos_rpc, (a1 != 0) ? br_target : br_fall, tos_mask};
        end
      end
      m_exp = e;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input out_t want);
    n_cmp++;
    if (dut_out !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, dut_out, want);
    end
  endtask

  task automatic clr();
    br_valid = 0; br_warp = 0; br_taken = 0; tos_mask = 0;
    br_target = 0; br_fall = 0; br_reconv = 0; tos_rpc = 0;
    iss_valid = 0; iss_warp = 0; iss_next = 0; iss_rpc = 0;
  endtask

  task automatic set_br(input logic [2:0] w, input logic [7:0] t, input logic [7:0] m,
                        input logic [11:0] tg, input logic [11:0] fl, input logic [11:0] rc,
                        input logic [11:0] rp);
    br_valid = 1; br_warp = w; br_taken = t; tos_mask = m;
    br_target = tg; br_fall = fl; br_reconv = rc; tos_rpc = rp;
  endtask

  task automatic set_iss(input logic [2:0] w, input logic [11:0] nx, input logic [11:0] rp);
    iss_valid = 1; iss_warp = w; iss_next = nx; iss_rpc = rp;
  endtask

  vec_t vecs[10];

  localparam logic [31:0] P_DIV_TOS  = 32'hFFF080FF;
  localparam logic [31:0] P_PUSH_TOS = 32'h0800400F;
  localparam logic [31:0] P_PUSH_SUB = 32'h080024F0;

  initial begin
    vecs[0] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,
                mk(8'b0000_0000, 0, 0, 0, 0, 0)};
    vecs[1] = '{1, 1, 8'hFF, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF, 0, 0, 0, 0,
                mk(8'b0001_0010, 1, 0, 0, 32'hFFF040FF, 0)};
    vecs[2] = '{1, 6, 8'h00, 8'hF0, 12'h040, 12'h024, 12'h080, 12'h100, 0, 0, 0, 0,
                mk(8'b0001_0001, 6, 0, 0, 32'h100024F0, 0)};
    vecs[3] = '{1, 2, 8'h00, 8'h00, 12'h040, 12'h030, 12'h080, 12'h200, 0, 0, 0, 0,
                mk(8'b0001_0011, 2, 0, 0, 32'h20003000, 0)};
    vecs[4] = '{1, 4, 8'h3C, 8'h3C, 12'h055, 12'h024, 12'h080, 12'h123, 0, 0, 0, 0,
                mk(8'b0001_0010, 4, 0, 0, 32'h1230553C, 0)};
    vecs[5] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 3, 12'h050, 12'h050,
                mk(8'b0000_0100, 0, 0, 3, 0, 0)};
    vecs[6] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 3, 12'hFFF, 12'hFFF,
                mk(8'b0000_0000, 0, 0, 0, 0, 0)};
    vecs[7] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3, 12'h050, 12'h050,
                mk(8'b0000_0000, 0, 0, 0, 0, 0)};
    vecs[8] = '{1, 1, 8'h0F, 8'h0F, 12'h010, 12'h024, 12'h080, 12'h060, 1, 7, 12'h060, 12'h060,
                mk(8'b0001_0110, 1, 0, 7, 32'h0600100F, 0)};
    vecs[9] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 3, 12'h051, 12'h050,
                mk(8'b0000_0000, 0, 0, 0, 0, 0)};

    clr();
    reset = 1;
    tick();
    tick();
    check("reset", mk(0, 0, 0, 0, 0, 0));
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      br_valid  = vecs[i].br_valid;  br_warp = vecs[i].br_warp;
      br_taken  = vecs[i].taken;     tos_mask = vecs[i].mask;
      br_target = vecs[i].target;    br_fall = vecs[i].fall;
      br_reconv = vecs[i].rc;        tos_rpc = vecs[i].rpc;
      iss_valid = vecs[i].iss_valid; iss_warp = vecs[i].iss_warp;
      iss_next  = vecs[i].iss_next;  iss_rpc = vecs[i].iss_rpc;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    clr();

    // divergent branch over two cycles
    set_br(1, 8'h0F, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF);
    tick(); check("div_branch", mk(8'b0101_0000, 1, 0, 0, P_DIV_TOS, 0));
    clr();
    tick(); check("div_push", mk(8'b1011_1000, 0, 1, 0, P_PUSH_TOS, P_PUSH_SUB));
    tick(); check("div_after", mk(0, 0, 0, 0, 0, 0));

    // other-warp reconv coincident with divergent branch
    set_br(5, 8'h0F, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF);
    set_iss(2, 12'h070, 12'h070);
    tick(); check("coinc_branch", mk(8'b0101_0000, 5, 0, 0, P_DIV_TOS, 0));
    clr();
    tick(); check("coinc_push_reconv", mk(8'b1011_1100, 0, 5, 2, P_PUSH_TOS, P_PUSH_SUB));
    tick(); check("coinc_after", mk(0, 0, 0, 0, 0, 0));

    // same-warp reconv during its own push
    set_br(5, 8'h0F, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF);
    tick(); check("same_branch", mk(8'b0101_0000, 5, 0, 0, P_DIV_TOS, 0));
    clr();
    set_iss(5, 12'h033, 12'h033);
    tick(); check("same_push_held", mk(8'b1011_1000, 0, 5, 0, P_PUSH_TOS, P_PUSH_SUB));
    clr();
    tick(); check("same_drain", mk(8'b0000_0100, 0, 0, 5, 0, 0));
    tick(); check("same_after", mk(0, 0, 0, 0, 0, 0));

    // stall between branch and push
    set_br(1, 8'h0F, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF);
    tick(); check("stall_branch", mk(8'b0101_0000, 1, 0, 0, P_DIV_TOS, 0));
    clr();
    stall = 1;
    set_iss(3, 12'h044, 12'h044);
    for (int k = 0; k < 3; k++) begin
      tick(); check($sformatf("stall_hold%0d", k), mk(8'b0101_0000, 1, 0, 0, P_DIV_TOS, 0));
    end
    stall = 0;
    clr();
    tick(); check("stall_push", mk(8'b1011_1000, 0, 1, 0, P_PUSH_TOS, P_PUSH_SUB));
    tick(); check("stall_once", mk(0, 0, 0, 0, 0, 0));

    // reset while in PUSH, with a held reconv that must be discarded
    set_br(5, 8'h0F, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF);
    set_iss(2, 12'h070, 12'h070);
    tick(); check("rst_branch", mk(8'b0101_0000, 5, 0, 0, P_DIV_TOS, 0));
    clr();
    reset = 1;
    tick(); check("rst_zero", mk(0, 0, 0, 0, 0, 0));
    reset = 0;
    set_br(3, 8'h0F, 8'hFF, 12'h040, 12'h024, 12'h080, 12'hFFF);
    tick(); check("rst_fresh_branch", mk(8'b0101_0000, 3, 0, 0, P_DIV_TOS, 0));
    clr();
    tick(); check("rst_fresh_push", mk(8'b1011_1000, 0, 3, 0, P_PUSH_TOS, P_PUSH_SUB));

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      clr();
      reset = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 9) == 0);
      if (!m_pend && $urandom_range(0, 1) == 1) begin
        br_valid  = 1;
        br_warp   = 3'($urandom_range(0, 3));
        tos_mask  = 8'($urandom);
        case ($urandom_range(0, 3))
          0, 3: br_taken = tos_mask & 8'($urandom);
          1:    br_taken = tos_mask;
          default: br_taken = 8'h00;
        endcase
        br_target = 12'($urandom);
        br_fall   = 12'($urandom);
        br_reconv = 12'($urandom);
        tos_rpc   = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_warp  = 3'($urandom_range(0, 3));
      iss_rpc   = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      iss_next  = ($urandom_range(0, 1) == 1) ? iss_rpc : 12'($urandom_range(0, 15));
      if (!reset && !stall && would_overflow()) iss_valid = 0;
      tick();
      check($sformatf("rand%0d", i), m_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simt_diverge_ctrl.md
# simt_diverge_ctrl

- Branch-divergence controller directly upstream of the per-warp SIMT stacks.
- Turns resolved branch outcomes and issued-warp next-PC checks into the stacks' control strobes and push packets:
  - `branch`, `pushState`, `pushTOS`, `pushTOSsub1`, `reconv`;
  - the branch-warp, pre-branch-warp and issued-warp IDs;
  - `{RPC,PC,Mask}` packets.
- Sequences each divergent branch over two cycles.
- Guarantees `branch` and `reconv` never reach the stacks in the same cycle.

## Interface
Parameters:
- PC_W, `SIZE_PC`, PC width
- LANES, `SIZE_CORE`, active-mask width
- WID_W, `NUM_WARP_LOG`, warp-ID width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall_i  in  1  pipeline stall; freezes all state and outputs
- br_valid_i  in  1  resolved branch present
- br_warp_i  in  WID_W  branching warp
- br_taken_i  in  LANES  per-lane taken mask (pre-ANDed with active mask)
- br_target_pc_i / br_fall_pc_i / br_reconv_pc_i  in  PC_W  taken target, fall-through, immediate post-dominator
- tos_rpc_i / tos_mask_i  in  PC_W / LANES  TOS RPC and mask of br_warp_i
- iss_valid_i  in  1  instruction issued
- iss_warp_i  in  WID_W  issued warp
- iss_next_pc_i  in  PC_W  issued warp's next PC
- iss_tos_rpc_i  in  PC_W  TOS RPC of iss_warp_i
- busy_o  out  1  high during the push cycle; br_valid_i must be low
- branch_o, pushState_o, pushTOS_o, pushTOSsub1_o, reconv_o  out  1 each  stack strobes
- mask0_all0_o, mask1_all0_o  out  1 each  not-taken mask zero / taken mask zero
- branchWarp_o, preBranchWarp_o, issuedWarp_o  out  WID_W  stack warp selects
- pushPacket_TOS_o, pushPacket_TOSsub1_o  out  2*PC_W+LANES  `{RPC,PC,Mask}`, RPC in MSBs

## Operation
- All outputs are registered.
- Reset value of every output is 0.
- FSM states:
  - IDLE → PUSH on a divergent branch.
  - PUSH → IDLE unconditionally.
- Per-branch signals: `m1 = br_taken_i`, `m0 = tos_mask_i & ~br_taken_i`.
- Uniform branch (m0==0 or m1==0), IDLE:
  - `pushTOS_o=1`, `branch_o=0`.
  - Packet = `{tos_rpc_i, m1?target:fall, tos_mask_i}`, an in-place PC update.
  - m1==m0==0 is treated as uniform not-taken.
- Divergent branch (both nonzero), IDLE:
  - `branch_o=1`, `pushTOS_o=1`.
  - Packet = `{tos_rpc_i, reconv_pc, tos_mask_i}`.
  - Latches warp, target, fall, reconv, m0, m1; go to PUSH.
- PUSH cycle outputs:
  - `pushState_o=1`, `preBranchWarp_o`=latched warp, `pushTOS_o=pushTOSsub1_o=1`, `busy_o=1`.
  - TOS packet = `{reconv, target, m1}`; taken path executes first.
  - TOSsub1 packet = `{reconv, fall, m0}`.
- `mask0_all0_o` / `mask1_all0_o` reflect m0/m1 of the branch presented in that cycle.
- Reconvergence:
  - Detect when `iss_valid_i && iss_next_pc_i == iss_tos_rpc_i && iss_tos_rpc_i != all-ones`.
  - All-ones is the bottom-entry sentinel.
- One-entry pending-reconv slot:
  - A detected reconv is emitted on `reconv_o`/`issuedWarp_o` unless a blocking condition holds, in which case it is captured in the slot.
  - Blocking conditions: `branch_o` is being asserted this cycle; or the warp equals the warp currently in PUSH.
  - The slot drains first in the next non-blocked cycle. A new detection that same cycle then goes to the slot.
  - A detection while the slot is full and still blocked is a protocol error. It is asserted in simulation and dropped.
- Strobe rules:
  - `branch_o` and `reconv_o` are never both 1.
  - `pushState_o` and `branch_o` are never both 1.

## Timing
- One-cycle latency from input sample to registered output.
- The stack acts on outputs in the following unstalled cycle.
- Divergent branch occupies 2 cycles; the next branch is accepted the cycle after PUSH.
- `stall_i=1`:
  - No input is sampled.
  - FSM, slot and outputs hold; the stacks also ignore held strobes.
- Reset mid-PUSH: FSM → IDLE, slot cleared, all outputs 0 next cycle. The partial push is abandoned.
- br_valid_i during PUSH: ignored; asserted in simulation.

## Configuration
- `SIMT_DIVERGE_STATS_EN` defined:
  - Adds outputs `stat_div_o`, `stat_uni_o`, `stat_reconv_o`, each 32 bits.
  - These are saturating counters of divergent branches, uniform branches and emitted reconvs.
  - Counters increment on unstalled events and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `gpgpu_simt_pkg`:
  - packet field offsets (RPC/PC/Mask slices);
  - RPC sentinel constant;
  - FSM state encoding.
- One sub-module, `reconv_slot`: the detection compare plus the one-entry holding register with block/drain logic.

## Test plan
- LANES=8, mask FF, taken 0F, target 0x40, fall 0x24, reconv 0x80, RPC FFF:
  - cycle 1: branch=1, TOS pkt {FFF,80,FF};
  - cycle 2: pushState=1, pkts {80,40,0F} / {80,24,F0}.
- Taken FF of mask FF, target 0x40 → pushTOS only, branch=0, pkt {RPC,40,FF}, mask0_all0=1.
- Warp 2 reconv detected in the same cycle as warp 5 divergent branch → branch_o first, reconv_o (issuedWarp=2) exactly one cycle later, never coincident.
- Reconv for warp 5 during warp 5 PUSH → held; emitted the cycle after PUSH ends.
- stall_i high 3 cycles between branch and PUSH → outputs frozen; PUSH emitted once after release.
- Reset asserted in PUSH → all outputs 0 next cycle; a fresh branch is accepted immediately after.
